// File: rtl/mem_arbiter_if.sv
// Shared bus widths and the request/response bus used by both requesters and the memory port.
// The arbiter is the slave of each requester bus and the master of the memory bus.
package simple_processor_pkg;
  parameter int ADDR_WIDTH = 16;
  parameter int DATA_WIDTH = 16;
endpackage

interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port: instruction and data masters share
// one bus, ties alternate, and a stalled memory is cut off after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk_i,
  input  logic          arst_i,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic       GRANT_I  = 1'b0;
  localparam logic       GRANT_D  = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  imem_ack_s, imem_err_s;
  logic                  dmem_ack_s, dmem_err_s;
  logic [DATA_WIDTH-1:0] imem_rdata_s, dmem_rdata_s;
  logic                  unused_s;

  // State register and latched memory-port request fields
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Arbitration, completion/timeout detection and combinational response routing
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_ack_s   = 1'b0;
    imem_err_s   = 1'b0;
    imem_rdata_s = {DATA_WIDTH{1'b0}};
    dmem_ack_s   = 1'b0;
    dmem_err_s   = 1'b0;
    dmem_rdata_s = {DATA_WIDTH{1'b0}};

    case (state_q)
      IDLE: begin
        // Data wins when alone or when instruction held the port last
        if (dmem.req && (!imem.req || (last_grant_q == GRANT_I))) begin
          state_d     = BUSY_D;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = dmem.we;
          mem_addr_d  = dmem.addr;
          mem_wdata_d = dmem.wdata;
        end else if (imem.req) begin
          state_d     = BUSY_I;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = imem.addr;
          mem_wdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // A real ack in the last allowed cycle beats the timeout
        if (mem.ack || (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            last_grant_d = GRANT_D;
            dmem_ack_s   = 1'b1;
            dmem_err_s   = !mem.ack;
            dmem_rdata_s = mem.ack ? mem.rdata : {DATA_WIDTH{1'b0}};
          end else begin
            last_grant_d = GRANT_I;
            imem_ack_s   = 1'b1;
            imem_err_s   = !mem.ack;
            imem_rdata_s = mem.ack ? mem.rdata : {DATA_WIDTH{1'b0}};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem.req     = mem_req_q;
  assign mem.we      = mem_we_q;
  assign mem.addr    = mem_addr_q;
  assign mem.wdata   = mem_wdata_q;

  assign imem.ack    = imem_ack_s;
  assign imem.err    = imem_err_s;
  assign imem.rdata  = imem_rdata_s;
  assign dmem.ack    = dmem_ack_s;
  assign dmem.err    = dmem_err_s;
  assign dmem.rdata  = dmem_rdata_s;

  // Instruction side never writes and the memory never reports errors
  assign unused_s    = ^{imem.we, imem.wdata, mem.err};

endmodule
